// File: rtl/dmg_oam_dma.sv
// OAM DMA controller: copies a 160-byte page into OAM and arbitrates the main bus
// between the CPU and the DMA engine while the copy runs.
module dmg_oam_dma #(
    parameter int unsigned MCYCLE_CLKS   = 4,
    parameter int unsigned START_MCYCLES = 1,
    parameter int unsigned XFER_LEN      = 160
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic [15:0] mem_a,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  oam_a,
    output logic [7:0]  oam_d,
    output logic        oam_wr,
    output logic        dma_active
);

    localparam int unsigned StartClks = START_MCYCLES * MCYCLE_CLKS;
    localparam int unsigned PhW       = $clog2(MCYCLE_CLKS);
    localparam int unsigned CntW      = $clog2(StartClks + 1);
    localparam logic [PhW-1:0]  PhLast  = PhW'(MCYCLE_CLKS - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(StartClks - 1);
    localparam logic [7:0]      IdxLast = 8'(XFER_LEN - 1);

    typedef enum logic [1:0] {StIdle, StStart, StXfer} state_e;

    state_e          state_q, state_d;
    logic [7:0]      page_q, page_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      data_q, data_d;
    logic [PhW-1:0]  phase_q, phase_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic ff46_sel, ff46_wr, hi_page;

    assign ff46_sel = (cpu_a == 16'hFF46);
    assign ff46_wr  = cpu_wr && ff46_sel;
    assign hi_page  = (cpu_a[15:8] == 8'hFF);

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        case (state_q)
            StStart: begin
                if (cnt_q == CntLast) begin
                    state_d = StXfer;
                    phase_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StXfer: begin
                // mem_din is valid the clock after the phase-0 read strobe
                if (phase_q == PhW'(1)) data_d = mem_din;
                if (phase_q == PhLast) begin
                    phase_d = '0;
                    idx_d   = idx_q + 8'd1;
                    if (idx_q == IdxLast) state_d = StIdle;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: ;
        endcase
        // A page write restarts the engine from any state, including the final byte.
        if (ff46_wr) begin
            page_d  = cpu_dout;
            idx_d   = '0;
            phase_d = '0;
            cnt_d   = '0;
            state_d = StStart;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            page_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            phase_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        mem_a      = cpu_a;
        mem_dout   = cpu_dout;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        cpu_din    = 8'hFF;
        oam_a      = idx_q;
        oam_d      = data_q;
        oam_wr     = 1'b0;
        dma_active = (state_q != StIdle);
        if (state_q == StXfer) begin
            mem_a    = {page_q, idx_q};
            mem_dout = '0;
            mem_rd   = (phase_q == '0);
            oam_wr   = (phase_q == PhLast);
        end else if (state_q == StStart) begin
            mem_a    = {page_q, idx_q};
            mem_dout = '0;
        end else if (!RESET && !hi_page) begin
            mem_rd  = cpu_rd;
            mem_wr  = cpu_wr;
            cpu_din = mem_din;
        end
        if (ff46_sel) cpu_din = page_q;
    end

endmodule

// File: tb/tb_dmg_oam_dma.sv
// Bench for dmg_oam_dma: idle bus vectors from a table, then scoreboarded OAM transfers
// covering CPU blocking, mid-transfer restart, restart on the final byte and reset.
module tb_dmg_oam_dma;

    localparam int XL = 160;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] cpu_a = '0;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_din;
    logic [15:0] mem_a;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = '0;
    logic        mem_rd, mem_wr;
    logic [7:0]  oam_a, oam_d;
    logic        oam_wr, dma_active;

    dmg_oam_dma dut (
        .CLK(CLK), .RESET(RESET), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_rd(cpu_rd),
        .cpu_wr(cpu_wr), .cpu_din(cpu_din), .mem_a(mem_a), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr), .oam_a(oam_a), .oam_d(oam_d),
        .oam_wr(oam_wr), .dma_active(dma_active)
    );

    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int          n_pulses = 0;
    bit          first_pending = 1'b0;
    int unsigned start_cyc = 0;
    int unsigned prev_cyc = 0;
    logic [15:0] last_rd_a = '0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  d;
        logic [15:0] ma;
    } oam_exp_t;
    oam_exp_t exp_q[$];
    oam_exp_t mon_e;

    // Main-bus memory: data for a read appears the clock after mem_rd.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_din <= mem_a[7:0] ^ 8'h5A;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (dma_active) begin
            chk("no_cpu_mem_wr", {31'd0, mem_wr}, 32'd0);
            if (mem_rd) last_rd_a = mem_a;
        end
        if (oam_wr) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_oam_wr: got oam_a=%0h expected no write", oam_a);
            end else begin
                mon_e = exp_q.pop_front();
                chk("oam_a", {24'd0, oam_a}, {24'd0, mon_e.a});
                chk("oam_d", {24'd0, oam_d}, {24'd0, mon_e.d});
                chk("src_mem_a", {16'd0, last_rd_a}, {16'd0, mon_e.ma});
                if (first_pending) chk("first_latency", cyc - start_cyc, 32'd7);
                else               chk("pulse_spacing", cyc - prev_cyc, 32'd4);
                first_pending = 1'b0;
                prev_cyc = cyc;
                n_pulses++;
            end
        end
    end

    // Called at edge+1; returns at edge+1 after the write was sampled.
    task automatic ff46_write(input logic [7:0] pg, input bit flush);
        cpu_a = 16'hFF46; cpu_dout = pg; cpu_wr = 1'b1; cpu_rd = 1'b0;
        @(posedge CLK); #1;
        cpu_wr = 1'b0; cpu_a = 16'h0000; cpu_dout = 8'h00;
        if (flush) exp_q.delete();
        for (int i = 0; i < XL; i++) exp_q.push_back('{8'(i), 8'(i) ^ 8'h5A, {pg, 8'(i)}});
        start_cyc = cyc;
        first_pending = 1'b1;
        n_pulses = 0;
    endtask

    task automatic wait_pulses(input int target);
        int k;
        k = 0;
        while (n_pulses < target && k < 2000) begin
            @(posedge CLK); #1;
            k++;
        end
        if (n_pulses < target) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_pulses: got %0d expected %0d", n_pulses, target);
        end
    endtask

    task automatic run_to_idle(output int edges);
        edges = 0;
        while (dma_active && edges < 2000) begin
            @(posedge CLK); #1;
            edges++;
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [7:0]  dout;
        logic        rd, wr;
        logic [15:0] ema;
        logic        erd, ewr;
        bit          chk_din;
        logic [7:0]  edin;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int n;
        vecs[0] = '{16'h1234, 8'h00, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{16'h8000, 8'h00, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 8'h5A};
        vecs[2] = '{16'hC0A5, 8'h3C, 1'b0, 1'b1, 16'hC0A5, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{16'hFF46, 8'h00, 1'b1, 1'b0, 16'hFF46, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[4] = '{16'hFF40, 8'h00, 1'b1, 1'b0, 16'hFF40, 1'b0, 1'b0, 1'b1, 8'hFF};
        vecs[5] = '{16'hFF80, 8'h99, 1'b0, 1'b1, 16'hFF80, 1'b0, 1'b0, 1'b1, 8'hFF};
        vecs[6] = '{16'h7FFF, 8'h00, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b1, 8'hA5};
        vecs[7] = '{16'hFEFF, 8'h00, 1'b1, 1'b0, 16'hFEFF, 1'b1, 1'b0, 1'b1, 8'hA5};

        RESET = 1'b1;
        repeat (4) @(posedge CLK);
        #1 RESET = 1'b0;
        #1;
        chk("reset_dma_active", {31'd0, dma_active}, 32'd0);
        chk("reset_oam_wr", {31'd0, oam_wr}, 32'd0);

        // Idle pass-through and high-page decode
        foreach (vecs[i]) begin
            cpu_a = vecs[i].a; cpu_dout = vecs[i].dout;
            cpu_rd = vecs[i].rd; cpu_wr = vecs[i].wr;
            #1;
            chk("idle_mem_a", {16'd0, mem_a}, {16'd0, vecs[i].ema});
            chk("idle_mem_dout", {24'd0, mem_dout}, {24'd0, vecs[i].dout});
            chk("idle_mem_rd", {31'd0, mem_rd}, {31'd0, vecs[i].erd});
            chk("idle_mem_wr", {31'd0, mem_wr}, {31'd0, vecs[i].ewr});
            chk("idle_dma_active", {31'd0, dma_active}, 32'd0);
            @(posedge CLK); #1;
            if (vecs[i].chk_din) chk("idle_cpu_din", {24'd0, cpu_din}, {24'd0, vecs[i].edin});
        end
        cpu_a = 16'h0000; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_dout = 8'h00;
        @(posedge CLK); #1;

        // Full transfer from page C1 with CPU accesses blocked along the way
        ff46_write(8'hC1, 1'b1);
        n = 0;
        while (dma_active && n < 2000) begin
            case (n)
                100: begin cpu_a = 16'h8000; cpu_rd = 1'b1; end
                101: begin cpu_rd = 1'b0; cpu_a = 16'hC000; cpu_dout = 8'h77; cpu_wr = 1'b1; end
                102: begin cpu_wr = 1'b0; cpu_a = 16'hFF46; cpu_rd = 1'b1; end
                103: begin cpu_rd = 1'b0; cpu_a = 16'h0000; cpu_dout = 8'h00; end
                default: ;
            endcase
            #1;
            if (n == 100) begin
                chk("blocked_rd_din", {24'd0, cpu_din}, 32'hFF);
                chk("blocked_rd_mem_page", {24'd0, mem_a[15:8]}, 32'hC1);
            end
            if (n == 101) chk("blocked_wr_mem_wr", {31'd0, mem_wr}, 32'd0);
            if (n == 102) chk("ff46_read_busy", {24'd0, cpu_din}, 32'hC1);
            @(posedge CLK); #1;
            n++;
        end
        chk("xfer_total_clks", n, 32'd644);
        chk("xfer_pulses", n_pulses, 32'd160);
        chk("xfer_queue_empty", exp_q.size(), 32'd0);
        cpu_a = 16'h1234;
        #1 chk("post_xfer_mem_a", {16'd0, mem_a}, 32'h1234);

        // Restart with a new page at idx 0x40
        ff46_write(8'hC1, 1'b1);
        wait_pulses(64);
        ff46_write(8'hD0, 1'b1);
        chk("restart_dma_active", {31'd0, dma_active}, 32'd1);
        run_to_idle(n);
        chk("restart_total_clks", n, 32'd644);
        chk("restart_pulses", n_pulses, 32'd160);
        chk("restart_queue_empty", exp_q.size(), 32'd0);

        // Page write on the same clock as the final OAM write
        ff46_write(8'hC1, 1'b1);
        wait_pulses(159);
        repeat (3) begin @(posedge CLK); #1; end
        chk("final_phase_oam_wr", {31'd0, oam_wr}, 32'd1);
        chk("final_phase_oam_a", {24'd0, oam_a}, 32'h9F);
        ff46_write(8'hE0, 1'b0);
        chk("final_byte_written", exp_q.size(), 32'd160);
        chk("collide_restart_active", {31'd0, dma_active}, 32'd1);
        run_to_idle(n);
        chk("collide_total_clks", n, 32'd644);
        chk("collide_queue_empty", exp_q.size(), 32'd0);

        // Reset in the middle of a transfer
        ff46_write(8'hC1, 1'b1);
        wait_pulses(32);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        exp_q.delete();
        chk("midreset_dma_active", {31'd0, dma_active}, 32'd0);
        cpu_a = 16'hFF46;
        #1 chk("midreset_ff46", {24'd0, cpu_din}, 32'h00);
        cpu_a = 16'h0000;
        repeat (200) @(posedge CLK);
        #1 chk("midreset_no_more_pulses", n_pulses, 32'd32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
